// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with an 8-bit register pointer and a
// register-bank write strobe / combinational read port.
// Transfer format: [START] addr+W, reg, data... [STOP]
//                  [START] addr+W, reg, [Sr] addr+R, data... NACK [STOP]
// Optional build macro: I2C_TARGET_AUTOINC_EN -- the register pointer
// advances after every written byte and after every read byte the master ACKs.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_MACK,
    S_WAIT_STOP
  } state_t;

  localparam int unsigned SYNC_MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic                   bus_cond;

  state_t     state;
  state_t     state_d;
  logic [3:0] bit_cnt;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       mack_q;
  logic       byte_end;
  logic       ack_end;
  logic       counting;
  logic       shift_in;

  // Input synchronisers plus one-cycle history for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: synchronisers reset to the idle-bus level (1) so that leaving
      // reset can never be mistaken for a START or an SCL edge.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what builds a real shift chain.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_q    <= scl_sync[SYNC_MSB];
      sda_q    <= sda_sync[SYNC_MSB];
    end
  end

  assign scl_s     = scl_sync[SYNC_MSB];
  assign sda_s     = sda_sync[SYNC_MSB];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign bus_cond  = start_det | stop_det;

  // A byte phase ends on the fall after its 8th rise; an ACK phase on the
  // fall after its single (9th) rise.
  assign byte_end = scl_fall & (bit_cnt == 4'd8);
  assign ack_end  = scl_fall & (bit_cnt == 4'd1);
  assign counting = (state != S_IDLE) & (state != S_WAIT_STOP);
  assign shift_in = (state == S_ADDR) | (state == S_REG) | (state == S_WDATA);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic: bus conditions win over everything else.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch appears.
    state_d = state;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      case (state)
        S_ADDR:      if (byte_end) state_d = (shift_q[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (ack_end)  state_d = rw_q ? S_RDATA : S_REG;
        S_REG:       if (byte_end) state_d = S_REG_ACK;
        S_REG_ACK:   if (ack_end)  state_d = S_WDATA;
        S_WDATA:     if (byte_end) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (ack_end)  state_d = S_WDATA;
        S_RDATA:     if (byte_end) state_d = S_MACK;
        S_MACK:      if (ack_end)  state_d = mack_q ? S_RDATA : S_WAIT_STOP;
        default:     state_d = state;
      endcase
    end
  end

  // Outputs decoded from state; SDA only ever pulled low, never driven high.
  always_comb begin
    o_sda_oe = 1'b0;
    o_busy   = 1'b0;
    case (state)
      S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
        o_sda_oe = 1'b1;
        o_busy   = 1'b1;
      end
      S_REG, S_WDATA, S_MACK: o_busy = 1'b1;
      S_RDATA: begin
        o_sda_oe = ~shift_q[7];
        o_busy   = 1'b1;
      end
      default: begin
        o_sda_oe = 1'b0;
        o_busy   = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register and captured R/W / master-ACK flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      mack_q  <= 1'b0;
    end else begin
      if (bus_cond || (state_d != state)) bit_cnt <= '0;
      else if (scl_rise && counting)      bit_cnt <= bit_cnt + 4'd1;

      if (!bus_cond) begin
        if (scl_rise && shift_in)
          shift_q <= {shift_q[6:0], sda_s};
        else if ((state_d == S_RDATA) && (state != S_RDATA))
          shift_q <= i_reg_rdata;
        else if ((state == S_RDATA) && scl_fall)
          shift_q <= {shift_q[6:0], 1'b1};

        if ((state == S_ADDR) && byte_end) rw_q   <= shift_q[0];
        if ((state == S_MACK) && scl_rise) mack_q <= ~sda_s;
      end
    end
  end

  // Register-bank side: pointer, write data and one-cycle write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_wr    <= 1'b0;
    end else begin
      o_reg_wr <= 1'b0;
      if (!bus_cond && (state == S_WDATA) && scl_rise && (bit_cnt == 4'd7)) begin
        o_reg_wr    <= 1'b1;
        o_reg_wdata <= {shift_q[6:0], sda_s};
      end
      if (!bus_cond && (state == S_REG) && byte_end)
        o_reg_addr <= shift_q;
`ifdef I2C_TARGET_AUTOINC_EN
      else if (o_reg_wr)
        o_reg_addr <= o_reg_addr + 8'd1;
      else if (!bus_cond && (state == S_MACK) && scl_rise && !sda_s)
        o_reg_addr <= o_reg_addr + 8'd1;
`endif
    end
  end

endmodule
